// File: rtl/carrd_issue_bridge.sv
// Carrd vector coprocessor issue bridge: instruction FIFO, one-at-a-time issue, scalar writeback return.
// Optional WAIT watchdog with sticky o_err is compiled in when CARRD_ISSUE_TIMEOUT_EN is defined.
module carrd_issue_bridge #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                       i_clk,
    input  logic                       i_nrst,
    input  logic                       i_req_valid,
    output logic                       o_req_ready,
    input  logic [31:0]                i_req_instr,
    input  logic [31:0]                i_req_xdata,
    output logic                       o_cp_valid,
    output logic [31:0]                o_cp_instr,
    output logic [31:0]                o_cp_xdata,
    input  logic                       i_cp_done,
    input  logic                       i_cp_x_wr_en,
    input  logic [31:0]                i_cp_x_data,
    output logic                       o_resp_valid,
    input  logic                       i_resp_ready,
    output logic [31:0]                o_resp_data,
    output logic [4:0]                 o_resp_rd,
    output logic                       o_busy,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t        r_state;
    logic [63:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_cp_valid;
    logic [31:0]   r_cp_instr;
    logic [31:0]   r_cp_xdata;
    logic          r_resp_valid;
    logic [31:0]   r_resp_data;
    logic [4:0]    r_resp_rd;

    logic          w_req_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_is_vcfg;
    logic [63:0]   w_head;

`ifdef CARRD_ISSUE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_timer;
    logic          r_err;
`endif

    // No bypass: a full FIFO refuses even when the head pops this cycle.
    assign w_req_ready = (r_count < CW'(DEPTH));
    assign w_push      = i_req_valid && w_req_ready;
    assign w_pop       = (r_state == S_ISSUE);
    assign w_head      = r_mem[r_rd_ptr];
    // vsetvli/vsetivli/vsetvl retire on issue; the coprocessor sends no completion for them.
    assign w_is_vcfg   = (r_cp_instr[6:0] == 7'b1010111) && (r_cp_instr[14:12] == 3'b111);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {i_req_xdata, i_req_instr};
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_cp_valid   <= 1'b0;
            r_cp_instr   <= '0;
            r_cp_xdata   <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_rd    <= '0;
`ifdef CARRD_ISSUE_TIMEOUT_EN
            r_timer      <= '0;
            r_err        <= 1'b0;
`endif
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);

            case (r_state)
                S_IDLE: begin
                    if (r_count != '0) begin
                        r_state    <= S_ISSUE;
                        r_cp_valid <= 1'b1;
                        r_cp_instr <= w_head[31:0];
                        r_cp_xdata <= w_head[63:32];
                    end
                end
                S_ISSUE: begin
                    r_cp_valid <= 1'b0;
                    if (w_is_vcfg) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_WAIT;
`ifdef CARRD_ISSUE_TIMEOUT_EN
                        r_timer <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (i_cp_done) begin
                        if (i_cp_x_wr_en) begin
                            r_resp_data  <= i_cp_x_data;
                            r_resp_rd    <= r_cp_instr[11:7];
                            r_resp_valid <= 1'b1;
                            r_state      <= S_RESP;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
`ifdef CARRD_ISSUE_TIMEOUT_EN
                    else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
`endif
                end
                S_RESP: begin
                    if (i_resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_req_ready  = w_req_ready;
    assign o_cp_valid   = r_cp_valid;
    assign o_cp_instr   = r_cp_instr;
    assign o_cp_xdata   = r_cp_xdata;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_data  = r_resp_data;
    assign o_resp_rd    = r_resp_rd;
    assign o_busy       = (r_state != S_IDLE) || (r_count != '0);
    assign o_count      = r_count;
`ifdef CARRD_ISSUE_TIMEOUT_EN
    assign o_err        = r_err;
`else
    assign o_err        = 1'b0;
`endif

endmodule

// File: tb/tb_carrd_issue_bridge.sv
// Self-checking bench for carrd_issue_bridge: vector table, corner-case sequences, randomized run against a queue model.
// Timeout sequence is exercised when CARRD_ISSUE_TIMEOUT_EN is defined.
module tb_carrd_issue_bridge;
    logic        clk;
    logic        nrst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_instr;
    logic [31:0] req_xdata;
    logic        cp_valid;
    logic [31:0] cp_instr;
    logic [31:0] cp_xdata;
    logic        cp_done;
    logic        cp_x_wr_en;
    logic [31:0] cp_x_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        busy;
    logic [2:0]  count;
    logic        err;

    carrd_issue_bridge #(.DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
        .i_clk        (clk),
        .i_nrst       (nrst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_instr  (req_instr),
        .i_req_xdata  (req_xdata),
        .o_cp_valid   (cp_valid),
        .o_cp_instr   (cp_instr),
        .o_cp_xdata   (cp_xdata),
        .i_cp_done    (cp_done),
        .i_cp_x_wr_en (cp_x_wr_en),
        .i_cp_x_data  (cp_x_data),
        .o_resp_valid (resp_valid),
        .i_resp_ready (resp_ready),
        .o_resp_data  (resp_data),
        .o_resp_rd    (resp_rd),
        .o_busy       (busy),
        .o_count      (count),
        .o_err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] xdata;
        logic        wr_en;
        logic [31:0] xres;
        int          delay;
        logic        exp_vcfg;
        logic        exp_resp;
        logic [4:0]  exp_rd;
    } vec_t;

    vec_t        vecs [6];
    int          n_checks;
    int          n_fail;
    logic [31:0] bi [6];
    int          acc_b;

    // Reference model state for the randomized run
    logic [31:0] q_i [$];
    logic [31:0] q_x [$];
    logic [36:0] q_r [$];
    int          m_push, m_iss, mc, dly;
    bit          outst, p_acc, p_iss, p_done, p_wr, p_hs;
    logic [31:0] p_in, p_xd, p_data, cur, rnd;

    localparam logic [31:0] VADD  = 32'h02208057;
    localparam logic [31:0] VADDC = 32'h02218057;
    localparam logic [31:0] RED   = 32'h420022D7;
    localparam logic [31:0] VSET  = 32'h0D0071D7;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cpv(input string name);
        int n;
        n = 0;
        while (!cp_valid && n < 40) begin
            tick();
            n++;
        end
        chk(name, 32'(cp_valid), 1);
    endtask

    task automatic tick_push();
        logic a;
        a = req_valid && req_ready;
        tick();
        if (a) begin
            acc_b++;
            if (acc_b < 6) req_instr = bi[acc_b];
            else req_valid = 1'b0;
        end
    endtask

    task automatic push_now(input logic [31:0] ins, input logic [31:0] xd);
        req_valid = 1'b1;
        req_instr = ins;
        req_xdata = xd;
        tick();
        req_valid = 1'b0;
    endtask

    function automatic bit is_vcfg(input logic [31:0] ins);
        return (ins[6:0] == 7'b1010111) && (ins[14:12] == 3'b111);
    endfunction

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no end expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        nrst = 1'b0; req_valid = 1'b0; req_instr = '0; req_xdata = '0;
        cp_done = 1'b0; cp_x_wr_en = 1'b0; cp_x_data = '0; resp_ready = 1'b0;

        vecs[0] = '{VADD,         32'h00000011, 1'b0, 32'h0,        2, 1'b0, 1'b0, 5'd0};
        vecs[1] = '{RED,          32'h00000022, 1'b1, 32'hDEADBEEF, 0, 1'b0, 1'b1, 5'd5};
        vecs[2] = '{VSET,         32'h00000033, 1'b0, 32'h0,        0, 1'b1, 1'b0, 5'd3};
        vecs[3] = '{32'h0E006FD7, 32'h00000044, 1'b1, 32'h12345678, 3, 1'b0, 1'b1, 5'd31};
        vecs[4] = '{32'h00007FA7, 32'h00000055, 1'b1, 32'hA5A50F0F, 1, 1'b0, 1'b1, 5'd31};
        vecs[5] = '{32'h80007057, 32'h00000066, 1'b0, 32'h0,        0, 1'b1, 1'b0, 5'd0};
        for (int k = 0; k < 6; k++) bi[k] = 32'h02008057 | (32'(k + 1) << 15);

        tick(); tick();
        nrst = 1'b1;
        tick();
        chk("reset count", 32'(count), 0);
        chk("reset req_ready", 32'(req_ready), 1);
        chk("reset cp_valid", 32'(cp_valid), 0);
        chk("reset resp_valid", 32'(resp_valid), 0);
        chk("reset err", 32'(err), 0);
        chk("reset busy", 32'(busy), 0);

        // Table: one instruction at a time from idle
        for (int v = 0; v < 6; v++) begin
            push_now(vecs[v].instr, vecs[v].xdata);
            chk($sformatf("tbl%0d count", v), 32'(count), 1);
            chk($sformatf("tbl%0d early cp_valid", v), 32'(cp_valid), 0);
            tick();
            chk($sformatf("tbl%0d cp_valid", v), 32'(cp_valid), 1);
            chk($sformatf("tbl%0d cp_instr", v), cp_instr, vecs[v].instr);
            chk($sformatf("tbl%0d cp_xdata", v), cp_xdata, vecs[v].xdata);
            tick();
            chk($sformatf("tbl%0d cp_valid pulse", v), 32'(cp_valid), 0);
            if (vecs[v].exp_vcfg) begin
                chk($sformatf("tbl%0d vcfg busy", v), 32'(busy), 0);
            end else begin
                chk($sformatf("tbl%0d wait busy", v), 32'(busy), 1);
                repeat (vecs[v].delay) tick();
                cp_done = 1'b1; cp_x_wr_en = vecs[v].wr_en; cp_x_data = vecs[v].xres;
                tick();
                cp_done = 1'b0; cp_x_wr_en = 1'b0;
                chk($sformatf("tbl%0d resp_valid", v), 32'(resp_valid), 32'(vecs[v].exp_resp));
                if (vecs[v].exp_resp) begin
                    chk($sformatf("tbl%0d resp_data", v), resp_data, vecs[v].xres);
                    chk($sformatf("tbl%0d resp_rd", v), 32'(resp_rd), 32'(vecs[v].exp_rd));
                    resp_ready = 1'b1;
                    tick();
                    resp_ready = 1'b0;
                    chk($sformatf("tbl%0d resp drop", v), 32'(resp_valid), 0);
                end
                chk($sformatf("tbl%0d busy end", v), 32'(busy), 0);
            end
            $display("vector %0d instr=0x%08h done", v, vecs[v].instr);
        end

        // Reset while WAIT with a second entry queued
        push_now(VADDC, 32'h1);
        push_now(RED, 32'h2);
        tick();
        #3 nrst = 1'b0;
        #1;
        chk("rstwait async count", 32'(count), 0);
        chk("rstwait async cp_instr", cp_instr, 0);
        chk("rstwait async req_ready", 32'(req_ready), 1);
        tick(); tick();
        nrst = 1'b1;
        tick();
        chk("rstwait count", 32'(count), 0);
        chk("rstwait req_ready", 32'(req_ready), 1);
        chk("rstwait resp_valid", 32'(resp_valid), 0);
        chk("rstwait err", 32'(err), 0);
        chk("rstwait busy", 32'(busy), 0);
        tick();
        chk("rstwait stays idle", 32'(cp_valid), 0);
        $display("sequence reset-in-WAIT done");

        // Reset while RESP
        push_now(RED, 32'h3);
        tick(); tick();
        cp_done = 1'b1; cp_x_wr_en = 1'b1; cp_x_data = 32'hCAFEF00D;
        tick();
        cp_done = 1'b0; cp_x_wr_en = 1'b0;
        chk("rstresp pre resp_valid", 32'(resp_valid), 1);
        nrst = 1'b0;
        #1;
        chk("rstresp resp_valid", 32'(resp_valid), 0);
        chk("rstresp resp_data", resp_data, 0);
        chk("rstresp resp_rd", 32'(resp_rd), 0);
        tick();
        nrst = 1'b1;
        tick();
        chk("rstresp busy", 32'(busy), 0);
        $display("sequence reset-in-RESP done");

        // Back-pressure: six offered, cp_done withheld
        acc_b = 0;
        req_valid = 1'b1; req_instr = bi[0]; req_xdata = 32'h0;
        repeat (8) tick_push();
        chk("full accepted", 32'(acc_b), 5);
        chk("full count", 32'(count), 4);
        chk("full req_ready", 32'(req_ready), 0);
        chk("full first issued", cp_instr, bi[0]);
        cp_done = 1'b1;
        tick_push();
        cp_done = 1'b0;
        for (int k = 1; k < 6; k++) begin
            int n;
            n = 0;
            while (!cp_valid && n < 20) begin
                tick_push();
                n++;
            end
            chk($sformatf("order%0d cp_valid", k), 32'(cp_valid), 1);
            chk($sformatf("order%0d cp_instr", k), cp_instr, bi[k]);
            if (k == 1) chk("no bypass req_ready", 32'(req_ready), 0);
            tick_push();
            cp_done = 1'b1;
            tick_push();
            cp_done = 1'b0;
        end
        chk("full all accepted", 32'(acc_b), 6);
        tick();
        chk("full drained busy", 32'(busy), 0);
        $display("sequence back-pressure done");

        // Scalar result held under resp_ready low; next issue waits for the handshake
        req_valid = 1'b1; req_instr = RED; req_xdata = 32'h7;
        tick();
        req_instr = VADDC;
        tick();
        req_valid = 1'b0;
        chk("red cp_valid", 32'(cp_valid), 1);
        chk("red cp_instr", cp_instr, RED);
        tick();
        cp_done = 1'b1; cp_x_wr_en = 1'b1; cp_x_data = 32'hDEADBEEF;
        tick();
        cp_done = 1'b0; cp_x_wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("hold%0d resp_valid", i), 32'(resp_valid), 1);
            chk($sformatf("hold%0d resp_data", i), resp_data, 32'hDEADBEEF);
            chk($sformatf("hold%0d resp_rd", i), 32'(resp_rd), 5);
            chk($sformatf("hold%0d cp_valid", i), 32'(cp_valid), 0);
            cp_done = 1'b1; cp_x_wr_en = 1'b1; cp_x_data = $urandom;
            tick();
            cp_done = 1'b0; cp_x_wr_en = 1'b0;
        end
        chk("hold final resp_data", resp_data, 32'hDEADBEEF);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("hs resp_valid drop", 32'(resp_valid), 0);
        chk("hs no issue yet", 32'(cp_valid), 0);
        tick();
        chk("hs next cp_valid", 32'(cp_valid), 1);
        chk("hs next cp_instr", cp_instr, VADDC);
        tick();
        cp_done = 1'b1;
        tick();
        cp_done = 1'b0;
        chk("hs busy end", 32'(busy), 0);
        $display("sequence scalar-hold done");

        // vsetvli then vadd: issue spacing of two cycles
        req_valid = 1'b1; req_instr = VSET; req_xdata = 32'h9;
        tick();
        req_instr = VADD;
        tick();
        req_valid = 1'b0;
        chk("vset cp_valid", 32'(cp_valid), 1);
        chk("vset cp_instr", cp_instr, VSET);
        tick();
        chk("vset gap", 32'(cp_valid), 0);
        tick();
        chk("vset second cp_valid", 32'(cp_valid), 1);
        chk("vset second cp_instr", cp_instr, VADD);
        tick();
        cp_done = 1'b1;
        tick();
        cp_done = 1'b0;
        chk("vset busy end", 32'(busy), 0);
        $display("sequence vconfig-spacing done");

        // Randomized run against queue model
        m_push = 0; m_iss = 0; outst = 0; dly = 0;
        p_acc = 0; p_iss = 0; p_done = 0; p_wr = 0; p_hs = 0;
        cur = '0; p_in = '0; p_xd = '0; p_data = '0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (p_acc) begin
                q_i.push_back(p_in);
                q_x.push_back(p_xd);
                m_push++;
            end
            if (p_iss) m_iss++;
            if (p_hs && q_r.size() > 0) q_r.delete(0);
            if (p_done) begin
                outst = 0;
                if (p_wr) q_r.push_back({p_data, cur[11:7]});
            end
            mc = m_push - m_iss;
            chk("rnd count", 32'(count), 32'(mc));
            chk("rnd req_ready", 32'(req_ready), 32'(mc < 4));
            chk("rnd resp_valid", 32'(resp_valid), 32'(q_r.size() > 0));
            if (resp_valid && q_r.size() > 0) begin
                chk("rnd resp_data", resp_data, q_r[0][36:5]);
                chk("rnd resp_rd", 32'(resp_rd), 32'(q_r[0][4:0]));
            end
            if (cp_valid) begin
                chk("rnd single in flight", 32'(outst || (q_r.size() > 0)), 0);
                chk("rnd issue has entry", 32'(q_i.size() > 0), 1);
                if (q_i.size() > 0) begin
                    chk("rnd cp_instr", cp_instr, q_i[0]);
                    chk("rnd cp_xdata", cp_xdata, q_x[0]);
                    cur = q_i[0];
                    q_i.delete(0);
                    q_x.delete(0);
                    if (!is_vcfg(cur)) begin
                        outst = 1;
                        dly = $urandom_range(1, 6);
                    end
                end
            end
            chk("rnd busy", 32'(busy), 32'((mc != 0) || cp_valid || outst || (q_r.size() > 0)));
            if (cyc >= 3000 && mc == 0 && !outst && q_r.size() == 0 && !cp_valid) break;

            p_iss = cp_valid;
            if (cyc < 3000 && $urandom_range(0, 2) != 0) begin
                rnd = $urandom;
                if ($urandom_range(0, 3) == 0) begin
                    rnd[6:0]   = 7'b1010111;
                    rnd[14:12] = 3'b111;
                end
                req_valid = 1'b1;
                req_instr = rnd;
                req_xdata = $urandom;
            end else begin
                req_valid = 1'b0;
            end
            p_acc = req_valid && req_ready;
            p_in  = req_instr;
            p_xd  = req_xdata;
            p_done = 0;
            if (outst && !cp_valid) begin
                dly--;
                cp_x_wr_en = 1'($urandom_range(0, 1));
                cp_x_data  = $urandom;
                cp_done    = (dly == 0);
                if (dly == 0) begin
                    p_done = 1;
                    p_wr   = cp_x_wr_en;
                    p_data = cp_x_data;
                end
            end else begin
                cp_done    = ($urandom_range(0, 7) == 0);
                cp_x_wr_en = 1'($urandom_range(0, 1));
                cp_x_data  = $urandom;
            end
            resp_ready = 1'($urandom_range(0, 1));
            p_hs = resp_valid && resp_ready;
            tick();
        end
        req_valid = 1'b0; cp_done = 1'b0; cp_x_wr_en = 1'b0; resp_ready = 1'b0;
        tick();
        chk("rnd drained busy", 32'(busy), 0);
        chk("rnd drained count", 32'(count), 0);
        chk("rnd err", 32'(err), 0);
        $display("random run: %0d pushed, %0d issued", m_push, m_iss);

`ifdef CARRD_ISSUE_TIMEOUT_EN
        push_now(VADDC, 32'h5);
        push_now(VADD, 32'h6);
        chk("to cp_instr", cp_instr, VADDC);
        tick();
        for (int i = 1; i < 8; i++) begin
            chk($sformatf("to err low %0d", i), 32'(err), 0);
            tick();
        end
        chk("to err low 8", 32'(err), 0);
        tick();
        chk("to err set", 32'(err), 1);
        chk("to no resp", 32'(resp_valid), 0);
        chk("to idle no issue", 32'(cp_valid), 0);
        tick();
        chk("to next cp_valid", 32'(cp_valid), 1);
        chk("to next cp_instr", cp_instr, VADD);
        tick();
        cp_done = 1'b1;
        tick();
        cp_done = 1'b0;
        chk("to err sticky", 32'(err), 1);
        chk("to busy end", 32'(busy), 0);
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        tick();
        chk("to err cleared", 32'(err), 0);
        $display("sequence timeout done");
`else
        push_now(VADDC, 32'h5);
        tick();
        tick();
        repeat (30) tick();
        chk("nto err", 32'(err), 0);
        chk("nto still busy", 32'(busy), 1);
        chk("nto no resp", 32'(resp_valid), 0);
        cp_done = 1'b1;
        tick();
        cp_done = 1'b0;
        chk("nto busy end", 32'(busy), 0);
        $display("sequence long-wait done");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
